// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default data width / depth and the helper that
// derives the pointer and fill-count width from a depth.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // Pointers and the count carry one extra bit so that a completely full
  // FIFO (count == DEPTH) is representable and pointer wrap is visible.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered status flags, sticky
// overflow/underflow flags, synchronous flush and optional first-word-fall-
// through read data.
//   clk, rstn        : clock, asynchronous active-low reset
//   i_wren, i_wrdata : write request and data
//   i_rden           : read request
//   i_flush          : empty the FIFO at the next edge
//   i_clr_err        : clear sticky error flags
//   o_rddata         : read data (registered, or head entry when FWFT=1)
//   o_full/o_alm_full/o_empty/o_alm_empty : status decoded from fill level
//   o_count          : fill level
//   o_overflow/o_underflow : sticky rejected-write / rejected-read flags
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int FWFT         = 0,
  parameter int ALM_FULL_TH  = DEPTH - 2,
  parameter int ALM_EMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_wren,
  input  logic                      i_rden,
  input  logic [DATA_W-1:0]         i_wrdata,
  input  logic                      i_flush,
  input  logic                      i_clr_err,
  output logic [DATA_W-1:0]         o_rddata,
  output logic                      o_full,
  output logic                      o_alm_full,
  output logic                      o_empty,
  output logic                      o_alm_empty,
  output logic [ptr_w(DEPTH)-1:0]   o_count,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int CW = ptr_w(DEPTH);
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL_LV = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LV   = CW'(ALM_FULL_TH);
  localparam logic [CW-1:0] AE_LV   = CW'(ALM_EMPTY_TH);

  // Reject illegal configurations while elaborating.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 4");
  end
  if ((ALM_FULL_TH < 1) || (ALM_FULL_TH > DEPTH - 1)) begin : g_bad_afth
    $error("param_sync_fifo: ALM_FULL_TH out of range 1..DEPTH-1");
  end
  if ((ALM_EMPTY_TH < 1) || (ALM_EMPTY_TH > DEPTH - 1)) begin : g_bad_aeth
    $error("param_sync_fifo: ALM_EMPTY_TH out of range 1..DEPTH-1");
  end
  if (DATA_W < 1) begin : g_bad_dw
    $error("param_sync_fifo: DATA_W must be >= 1");
  end

  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              wr_ok_s, rd_ok_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // A read needs data present; a write into a full FIFO is allowed only
  // when a read frees the head slot in the same cycle.
  assign rd_ok_s = i_rden & ~empty_q;
  assign wr_ok_s = i_wren & (~full_q | rd_ok_s);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok_s & ~i_flush),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (i_wrdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata_s)
  );

  // Next-state for pointers, fill level and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = {CW{1'b0}};
      rd_ptr_d = {CW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_d = wr_ptr_q + CW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A new error in the same cycle takes priority over the clear.
    if (i_wren & ~wr_ok_s) begin
      ovf_d = 1'b1;
    end else if (i_clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (i_rden & ~rd_ok_s) begin
      unf_d = 1'b1;
    end else if (i_clr_err) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // State registers; flags are decoded from the next count so they track
  // the registered count exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {CW{1'b0}};
      rd_ptr_q <= {CW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_LV);
      empty_q  <= (count_d == {CW{1'b0}});
      afull_q  <= (count_d >= AF_LV);
      aempty_q <= (count_d <= AE_LV);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is shown directly; forced to zero while empty so reset
    // leaves the output at zero.
    assign o_rddata = empty_q ? {DATA_W{1'b0}} : mem_rdata_s;
  end else begin : g_regrd
    logic [DATA_W-1:0] rddata_q;

    // Registered read data: captures the head on an accepted, non-flushed read
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rddata_q <= {DATA_W{1'b0}};
      end else if (rd_ok_s & ~i_flush) begin
        rddata_q <= mem_rdata_s;
      end else begin
        rddata_q <= rddata_q;
      end
    end

    assign o_rddata = rddata_q;
  end

  assign o_full      = full_q;
  assign o_alm_full  = afull_q;
  assign o_empty     = empty_q;
  assign o_alm_empty = aempty_q;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a registered-read instance (a_*) and a FWFT instance
// (b_*) share stimulus; a queue-based model predicts contents and flags.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wren = 1'b0, rden = 1'b0, flush = 1'b0, clr = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] a_rddata, b_rddata;
  logic       a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
  logic       b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
  logic [4:0] a_count, b_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rd;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0), .ALM_FULL_TH(14), .ALM_EMPTY_TH(2)) dut_a (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_rden(rden), .i_wrdata(wdata),
    .i_flush(flush), .i_clr_err(clr), .o_rddata(a_rddata), .o_full(a_full),
    .o_alm_full(a_afull), .o_empty(a_empty), .o_alm_empty(a_aempty),
    .o_count(a_count), .o_overflow(a_ovf), .o_underflow(a_unf));

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(1), .ALM_FULL_TH(14), .ALM_EMPTY_TH(2)) dut_b (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_rden(rden), .i_wrdata(wdata),
    .i_flush(flush), .i_clr_err(clr), .o_rddata(b_rddata), .o_full(b_full),
    .o_alm_full(b_afull), .o_empty(b_empty), .o_alm_empty(b_aempty),
    .o_count(b_count), .o_overflow(b_ovf), .o_underflow(b_unf));

  // Apply one cycle of stimulus, advance the model, settle 1 time unit past the edge.
  task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit f, input bit c);
    bit rd_acc, wr_acc;
    wren = w; rden = r; wdata = d; flush = f; clr = c;
    @(posedge clk);
    rd_acc = r && (q.size() != 0);
    wr_acc = w && ((q.size() != 16) || rd_acc);
    if (w && !wr_acc) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && !rd_acc) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (rd_acc) m_rd = q.pop_front();
      if (wr_acc) q.push_back(d);
    end
    #1;
    wren = 1'b0; rden = 1'b0; flush = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (a_count !== 5'd0 || b_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0", a_count, b_count); end
    checks++; if ({a_empty, a_aempty, a_full, a_afull} !== 4'b1100) begin errors++; $display("FAIL reset_flags_a got %b exp 1100", {a_empty, a_aempty, a_full, a_afull}); end
    checks++; if ({b_empty, b_aempty, b_full, b_afull} !== 4'b1100) begin errors++; $display("FAIL reset_flags_b got %b exp 1100", {b_empty, b_aempty, b_full, b_afull}); end
    checks++; if (a_rddata !== 8'h00 || b_rddata !== 8'h00) begin errors++; $display("FAIL reset_rddata got %h/%h exp 00", a_rddata, b_rddata); end
    checks++; if ({a_ovf, a_unf, b_ovf, b_unf} !== 4'b0000) begin errors++; $display("FAIL reset_err got %b exp 0000", {a_ovf, a_unf, b_ovf, b_unf}); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      checks++; if (a_count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", a_count, i + 1); end
      checks++; if (a_afull !== ((i + 1) >= 14)) begin errors++; $display("FAIL fill_alm_full n=%0d got %b exp %b", i + 1, a_afull, (i + 1) >= 14); end
      checks++; if (a_full !== (i == 15)) begin errors++; $display("FAIL fill_full n=%0d got %b exp %b", i + 1, a_full, i == 15); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (b_rddata !== 8'(i)) begin errors++; $display("FAIL drain_fwft_head got %h exp %h", b_rddata, 8'(i)); end
      drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++; if (a_rddata !== 8'(i)) begin errors++; $display("FAIL drain_rddata got %h exp %h", a_rddata, 8'(i)); end
    end
    checks++; if (a_empty !== 1'b1 || a_count !== 5'd0) begin errors++; $display("FAIL drain_empty got %b cnt %0d exp 1 cnt 0", a_empty, a_count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    checks++; if (a_ovf !== 1'b1 || b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b/%b exp 1", a_ovf, b_ovf); end
    checks++; if (a_count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", a_count); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", a_ovf); end
  endtask

  task automatic test_full_rw();
    logic [7:0] head;
    head = q[0];
    drive(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    checks++; if (a_count !== 5'd16 || a_full !== 1'b1) begin errors++; $display("FAIL full_rw_count got %0d full %b exp 16 full 1", a_count, a_full); end
    checks++; if (a_rddata !== head || a_ovf !== 1'b0) begin errors++; $display("FAIL full_rw_data got %h ovf %b exp %h ovf 0", a_rddata, a_ovf, head); end
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (a_rddata !== 8'hAA) begin errors++; $display("FAIL full_rw_last got %h exp aa", a_rddata); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (a_unf !== 1'b1 || b_unf !== 1'b1) begin errors++; $display("FAIL unf_set got %b/%b exp 1", a_unf, b_unf); end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", a_unf); end
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    checks++; if (a_count !== 5'd1 || a_unf !== 1'b1) begin errors++; $display("FAIL unf_rw_count got %0d unf %b exp 1 unf 1", a_count, a_unf); end
    checks++; if (b_rddata !== 8'h55) begin errors++; $display("FAIL unf_rw_head got %h exp 55", b_rddata); end
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    checks++; if (a_rddata !== 8'h55 || a_empty !== 1'b1) begin errors++; $display("FAIL unf_rw_read got %h empty %b exp 55 empty 1", a_rddata, a_empty); end
  endtask

  task automatic test_fwft();
    drive(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    checks++; if (b_rddata !== 8'h3C || b_empty !== 1'b0) begin errors++; $display("FAIL fwft_head got %h empty %b exp 3c empty 0", b_rddata, b_empty); end
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty got %b exp 1", b_empty); end
  endtask

  task automatic test_flush();
    logic [7:0] prev;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    checks++; if (a_count !== 5'd8) begin errors++; $display("FAIL flush_pre_count got %0d exp 8", a_count); end
    prev = a_rddata;
    drive(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    checks++; if (a_count !== 5'd0 || a_empty !== 1'b1 || b_empty !== 1'b1) begin errors++; $display("FAIL flush_state got %0d empty %b/%b exp 0 empty 1", a_count, a_empty, b_empty); end
    checks++; if (a_rddata !== prev || a_ovf !== 1'b0) begin errors++; $display("FAIL flush_rddata got %h ovf %b exp %h ovf 0", a_rddata, a_ovf, prev); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    wren = 1'b1; wdata = 8'h77;
    #3 rstn = 1'b0;
    #1;
    checks++; if (a_count !== 5'd0 || {a_empty, a_aempty, a_full, a_afull} !== 4'b1100) begin errors++; $display("FAIL areset_a got cnt %0d flags %b exp 0 1100", a_count, {a_empty, a_aempty, a_full, a_afull}); end
    checks++; if (a_rddata !== 8'h00 || b_rddata !== 8'h00 || b_count !== 5'd0) begin errors++; $display("FAIL areset_data got %h/%h cnt %0d exp 00/00 0", a_rddata, b_rddata, b_count); end
    checks++; if ({a_ovf, a_unf} !== 2'b00) begin errors++; $display("FAIL areset_err got %b exp 00", {a_ovf, a_unf}); end
    wren = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00;
    #1 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int wp, rp;
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) begin wp = $urandom_range(20, 90); rp = $urandom_range(20, 90); end
      drive(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), 8'($urandom),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0));
      checks++; if (a_count !== 5'(q.size()) || b_count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count n=%0d got %0d/%0d exp %0d", n, a_count, b_count, q.size()); end
      checks++; if ({a_full, a_afull, a_empty, a_aempty} !== {(q.size() == 16), (q.size() >= 14), (q.size() == 0), (q.size() <= 2)}) begin
        errors++; $display("FAIL rnd_flags n=%0d got %b size %0d", n, {a_full, a_afull, a_empty, a_aempty}, q.size()); end
      checks++; if (a_ovf !== m_ovf || a_unf !== m_unf) begin errors++; $display("FAIL rnd_err n=%0d got %b%b exp %b%b", n, a_ovf, a_unf, m_ovf, m_unf); end
      checks++; if (a_rddata !== m_rd) begin errors++; $display("FAIL rnd_rddata n=%0d got %h exp %h", n, a_rddata, m_rd); end
      if (q.size() != 0) begin
        checks++; if (b_rddata !== q[0]) begin errors++; $display("FAIL rnd_fwft n=%0d got %h exp %h", n, b_rddata, q[0]); end
      end
    end
  endtask

  initial begin
    m_ovf = 1'b0; m_unf = 1'b0; m_rd = 8'h00;
    #12;
    test_reset();
    @(posedge clk); #1 rstn = 1'b1;
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_fwft();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, entry count; power of two, >=4.
REQ-003 Parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter ALM_FULL_TH, default DEPTH-2, almost-full threshold (1..DEPTH-1).
REQ-005 Parameter ALM_EMPTY_TH, default 2, almost-empty threshold (1..DEPTH-1).
REQ-006 The port list SHALL be as follows; CW = $clog2(DEPTH)+1:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- i_wren  in  1  write request
- i_rden  in  1  read request
- i_wrdata  in  DATA_W  write data
- i_flush  in  1  synchronous flush
- i_clr_err  in  1  clears sticky error flags
- o_rddata  out  DATA_W  read data
- o_full, o_alm_full, o_empty, o_alm_empty  out  1 each  status flags
- o_count  out  CW  current fill level
- o_overflow, o_underflow  out  1 each  sticky error flags

Function
REQ-007 Write accepted on a rising clk edge when i_wren=1 and (o_full=0, or o_full=1 with a read accepted in the same cycle); accepted data stored at the tail.
REQ-008 Read accepted on a rising clk edge when i_rden=1 and o_empty=0; a read request while empty is rejected even if a write is accepted in the same cycle.
REQ-009 o_count changes as follows: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-010 Read/write pointers are CW bits wide, with an MSB wrap bit; wrap-around from DEPTH-1 to 0 is transparent to data ordering.
REQ-011 Status flags decode the registered o_count, so they update the cycle after an accepted operation:
- o_full = (count==DEPTH)
- o_empty = (count==0)
- o_alm_full = (count>=ALM_FULL_TH)
- o_alm_empty = (count<=ALM_EMPTY_TH)
REQ-012 FWFT=0: o_rddata is registered, presents the head entry one cycle after the accepted read, and holds its value otherwise.
REQ-013 FWFT=1: o_rddata equals the head entry whenever o_empty=0, with zero read latency; an accepted read advances to the next entry; the value is don't-care while empty.
REQ-014 o_overflow is set when i_wren=1 is rejected; o_underflow is set when i_rden=1 is rejected.
REQ-015 Both error flags stay set until a cycle with i_clr_err=1; a same-cycle set wins over the clear.
REQ-016 i_flush=1 zeroes both pointers and o_count at the next edge and overrides any same-cycle read/write; error flags and (FWFT=0) o_rddata are unaffected.

Reset
REQ-017 rstn=0 SHALL asynchronously force: pointers=0, o_count=0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0, o_overflow=0, o_underflow=0.
REQ-018 Storage array contents are not reset; reset mid-operation discards all entries.
REQ-019 Reset deassertion is synchronised to clk outside this block.

Structure
REQ-020 Shared package fifo_pkg holds DATA_W/DEPTH defaults and the derived pointer/count width function.
REQ-021 Storage is a sub-module fifo_mem: simple dual-port, one write port and one read port, synchronous write, asynchronous read.
REQ-022 An illegal DEPTH or out-of-range threshold is an elaboration-time error.

Verification
All scenarios use DATA_W=8, DEPTH=16, ALM_FULL_TH=14, ALM_EMPTY_TH=2.
REQ-023 Write 0x00..0x0F, then read 16 -> data in order; o_full=1 after the 16th write; o_alm_full=1 after the 14th write; o_empty=1 after the last read.
REQ-024 When full, a 17th write without a read -> data rejected, o_overflow=1, o_count=16; then i_clr_err pulse -> o_overflow=0.
REQ-025 When full, simultaneous write 0xAA and read -> both accepted; o_count stays 16; 0xAA is read out last.
REQ-026 When empty, read -> o_underflow=1; simultaneous write 0x55 and read while empty -> o_count=1, 0x55 retained.
REQ-027 FWFT=1: write 0x3C to an empty FIFO -> o_rddata=0x3C the next cycle with no read issued.
REQ-028 At 8 entries, pulse i_flush -> o_count=0 and o_empty=1 next cycle; rstn low mid-burst -> all outputs at reset values immediately, without waiting for clk.
